// File: rtl/lane_rr_scheduler_if.sv
// Lane-to-link handshake bundle for lane_rr_scheduler.
// lane_out exists only when LANE_SCHED_TAG_EN is defined.
interface lane_rr_scheduler_if;
  logic [7:0] data_in0;
  logic [7:0] data_in1;
  logic [7:0] data_in2;
  logic [7:0] data_in3;
  logic       valid_in0;
  logic       valid_in1;
  logic       valid_in2;
  logic       valid_in3;
  logic       ready_out0;
  logic       ready_out1;
  logic       ready_out2;
  logic       ready_out3;
  logic [7:0] data_out;
  logic       valid_out;
  logic       ready_in;
`ifdef LANE_SCHED_TAG_EN
  logic [1:0] lane_out;
`endif

  modport master (
`ifdef LANE_SCHED_TAG_EN
    input  lane_out,
`endif
    output data_in0, data_in1, data_in2, data_in3,
    output valid_in0, valid_in1, valid_in2, valid_in3,
    output ready_in,
    input  ready_out0, ready_out1, ready_out2, ready_out3,
    input  data_out, valid_out
  );

  modport slave (
`ifdef LANE_SCHED_TAG_EN
    output lane_out,
`endif
    input  data_in0, data_in1, data_in2, data_in3,
    input  valid_in0, valid_in1, valid_in2, valid_in3,
    input  ready_in,
    output ready_out0, ready_out1, ready_out2, ready_out3,
    output data_out, valid_out
  );
endinterface

// File: rtl/lane_rr_scheduler.sv
// Four-lane round-robin scheduler with burst lock onto one registered link word.
// Optional macro LANE_SCHED_TAG_EN adds the registered winner index lane_out.
module lane_rr_scheduler #(
  parameter int BURST  = 2,
  parameter int NLANES = 4
) (
  input logic                 clk_f,
  input logic                 reset,
  lane_rr_scheduler_if.slave  bus
);
  localparam int          CW      = $clog2(BURST + 1);
  localparam int unsigned NL      = NLANES;
  localparam logic [CW-1:0] BURST_C = CW'(BURST);
  localparam logic [0:0]  IDLE    = 1'b0;
  localparam logic [0:0]  LOCK    = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          valid_out_q, valid_out_d;
`ifdef LANE_SCHED_TAG_EN
  logic [1:0]    lane_q, lane_d;
`endif

  logic [NLANES-1:0] vin;
  logic [7:0]        din [NLANES];
  logic [NLANES-1:0] ready;
  logic              ld;
  logic              lock_hit;
  logic              found;
  logic [1:0]        start;
  logic [1:0]        idx;
  logic [1:0]        win;

  always_comb begin
    vin    = {bus.valid_in3, bus.valid_in2, bus.valid_in1, bus.valid_in0};
    din[0] = bus.data_in0;
    din[1] = bus.data_in1;
    din[2] = bus.data_in2;
    din[3] = bus.data_in3;

    ld       = !reset && (!valid_out_q || bus.ready_in);
    lock_hit = (state_q == LOCK) && vin[owner_q] && (cnt_q < BURST_C);
    start    = (state_q == LOCK) ? owner_q + 2'd1 : ptr_q;

    // Rotating first-valid search; may wrap back to the owner itself.
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NL; i++) begin
      idx = start + 2'(i);
      if (!found && vin[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (lock_hit) win = owner_q;

    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    ready       = '0;
`ifdef LANE_SCHED_TAG_EN
    lane_d      = lane_q;
`endif

    if (ld) begin
      if (lock_hit || found) begin
        ready[win]  = 1'b1;
        data_out_d  = din[win];
        valid_out_d = 1'b1;
`ifdef LANE_SCHED_TAG_EN
        lane_d      = win;
`endif
        if (lock_hit) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d   = CW'(1);
          owner_d = win;
          ptr_d   = win + 2'd1;
          state_d = LOCK;
        end
      end else begin
        state_d     = IDLE;
        valid_out_d = 1'b0;
        if (state_q == LOCK) ptr_d = owner_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_f) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
`ifdef LANE_SCHED_TAG_EN
      lane_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
`ifdef LANE_SCHED_TAG_EN
      lane_q      <= lane_d;
`endif
    end
  end

  assign bus.ready_out0 = ready[0];
  assign bus.ready_out1 = ready[1];
  assign bus.ready_out2 = ready[2];
  assign bus.ready_out3 = ready[3];
  assign bus.data_out   = data_out_q;
  assign bus.valid_out  = valid_out_q;
`ifdef LANE_SCHED_TAG_EN
  assign bus.lane_out   = lane_q;
`endif
endmodule
